// File: rtl/pricing_pkg.sv
// Shared types and helpers for the Monte-Carlo pricing aggregator.
package pricing_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REDUCE = 2'd2
    } state_t;

    localparam logic MODE_CALL = 1'b0;
    localparam logic MODE_PUT  = 1'b1;

    // Summing 2^log2_paths payoffs of data_w bits never needs more than this.
    function automatic int acc_w(input int data_w, input int log2_paths);
        return data_w + log2_paths;
    endfunction

endpackage

// File: rtl/pricing_lane_acc.sv
// Single payoff accumulator lane; cleared at the start of each run.
module pricing_lane_acc #(
    parameter int ACC_W = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] add_in,
    output logic [ACC_W-1:0] acc
);

    // Accumulate the payoffs routed to this lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + add_in;
        end
    end

endmodule

// File: rtl/pricing_aggregator.sv
// Averages call/put payoffs of a stream of terminal prices over one Monte-Carlo run.
// States:
//   IDLE   | waiting for start, holding the last price
//   RUN    | accepting samples, spreading payoffs round-robin over the lanes
//   REDUCE | folding one lane per cycle into the total, then publishing the price
module pricing_aggregator
    import pricing_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int NUM_LANES  = 4,
    parameter int LOG2_PATHS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] K,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] path,
    output logic [DATA_W-1:0] price,
    output logic              price_valid,
    output logic              busy
);

    localparam int ACC_W  = acc_w(DATA_W, LOG2_PATHS);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W  = (LOG2_PATHS > 0) ? LOG2_PATHS : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'((64'd1 << LOG2_PATHS) - 64'd1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    state_t             state, state_nxt;
    logic               run_clr;
    logic               accept;
    logic               last_sample;
    logic               last_lane;
    logic [DATA_W-1:0]  K_r;
    logic               mode_r;
    logic [DATA_W-1:0]  payoff;
    logic [CNT_W-1:0]   cnt;
    logic [LANE_W-1:0]  lane_sel;
    logic [LANE_W-1:0]  idx;
    logic [ACC_W-1:0]   lane_acc [NUM_LANES];
    logic [ACC_W-1:0]   total;
    logic [ACC_W-1:0]   sum_nxt;
    logic [DATA_W-1:0]  price_nxt;

    assign in_ready    = (state == RUN);
    assign busy        = (state != IDLE);
    assign accept      = in_valid && in_ready;
    assign last_sample = (cnt == LAST_CNT);
    assign last_lane   = (idx == LAST_LANE);
    assign lane_sel    = LANE_W'(int'(cnt) % NUM_LANES);
    assign sum_nxt     = total + lane_acc[idx];
    // The average of DATA_W-bit payoffs always fits back into DATA_W bits.
    assign price_nxt   = DATA_W'(sum_nxt >> LOG2_PATHS);

    // Payoff of the offered sample against the latched strike; clamps at zero.
    always_comb begin
        payoff = '0;
        if (mode_r == MODE_CALL) begin
            if (path > K_r) payoff = path - K_r;
        end else begin
            if (K_r > path) payoff = K_r - path;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and run-start clear.
    always_comb begin
        state_nxt = state;
        run_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    run_clr   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept && last_sample) state_nxt = REDUCE;
            end
            REDUCE: begin
                if (last_lane) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pricing_lane_acc #(
            .ACC_W(ACC_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (run_clr),
            .en    (accept && (lane_sel == LANE_W'(i))),
            .add_in(ACC_W'(payoff)),
            .acc   (lane_acc[i])
        );
    end

    // Run parameters, sample counter, lane reduction and the published price.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            K_r         <= '0;
            mode_r      <= MODE_CALL;
            cnt         <= '0;
            idx         <= '0;
            total       <= '0;
            price       <= '0;
            price_valid <= 1'b0;
        end else begin
            price_valid <= 1'b0;
            if (run_clr) begin
                K_r    <= K;
                mode_r <= mode;
                cnt    <= '0;
                idx    <= '0;
                total  <= '0;
            end
            // The counter wraps to zero on the last sample, ready for the next run.
            if (accept) cnt <= cnt + CNT_W'(1);
            if (state == REDUCE) begin
                total <= sum_nxt;
                idx   <= idx + LANE_W'(1);
                if (last_lane) begin
                    price       <= price_nxt;
                    price_valid <= 1'b1;
                end
            end
        end
    end

endmodule
